// File: rtl/vga_scanout.sv
// 640x480@60 VGA scan-out: pixel-tick timing, linear front-bank reads, registered
// pixel/sync/blank outputs and a vblank-aligned double-buffer swap.
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int ADDR_W   = 19,
    parameter int PIX_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              front_sel,
    output logic              refresh,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [PIX_W-1:0]  pix_out,
    output logic              hsync,
    output logic              vsync,
    output logic              blank_n
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          tick;
    logic          active;
    logic          h_wrap;
    logic          v_wrap;
    logic          hs_on;
    logic          vs_on;
    logic          vb_edge;

    // Position of the tick, captured so the output stage can pair it with rd_data
    logic          st_valid;
    logic          st_active;
    logic          st_hs;
    logic          st_vs;

    always_comb begin
        tick    = (int'(div) == CLK_DIV - 1);
        active  = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
        h_wrap  = (int'(h_cnt) == H_TOTAL - 1);
        v_wrap  = (int'(v_cnt) == V_TOTAL - 1);
        hs_on   = (int'(h_cnt) >= H_ACTIVE + H_FP) &&
                  (int'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
        vs_on   = (int'(v_cnt) >= V_ACTIVE + V_FP) &&
                  (int'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC);
        vb_edge = tick && h_wrap && (int'(v_cnt) == V_ACTIVE - 1);
        rd_en   = tick && active;
        rd_bank = front_sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div       <= '0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            rd_addr   <= '0;
            front_sel <= 1'b0;
            refresh   <= 1'b0;
            swap_ack  <= 1'b0;
        end else begin
            div      <= tick ? '0 : div + DW'(1);
            refresh  <= vb_edge;
            swap_ack <= vb_edge && swap_req;
            if (vb_edge && swap_req) begin
                front_sel <= ~front_sel;
            end
            if (tick) begin
                h_cnt <= h_wrap ? '0 : h_cnt + HW'(1);
                if (h_wrap) begin
                    v_cnt <= v_wrap ? '0 : v_cnt + VW'(1);
                end
                if (h_wrap && v_wrap) begin
                    rd_addr <= '0;
                end else if (active) begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                end
            end
        end
    end

    // rd_data arrives the clk after the read, so sync/blank ride one stage with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_valid  <= 1'b0;
            st_active <= 1'b0;
            st_hs     <= 1'b0;
            st_vs     <= 1'b0;
            blank_n   <= 1'b0;
            pix_out   <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
        end else begin
            st_valid <= tick;
            if (tick) begin
                st_active <= active;
                st_hs     <= hs_on;
                st_vs     <= vs_on;
            end
            if (st_valid) begin
                blank_n <= st_active;
                pix_out <= st_active ? rd_data : '0;
                hsync   <= ~st_hs;
                vsync   <= ~st_vs;
            end
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: default-timing line checks, a mid-size instance for
// swap behaviour, and a tiny instance checked every clk against an arithmetic model.
module tb_vga_scanout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // ---------------- instance A: default parameters ----------------
    logic        rst_a = 1'b1, req_a = 1'b0;
    logic        ack_a, fs_a, ref_a, en_a, bank_a, hs_a, vs_a, bl_a;
    logic [18:0] addr_a;
    logic [11:0] data_a = '0, pix_a;

    vga_scanout dut_a (
        .clk(clk), .rst(rst_a), .swap_req(req_a), .swap_ack(ack_a), .front_sel(fs_a),
        .refresh(ref_a), .rd_en(en_a), .rd_bank(bank_a), .rd_addr(addr_a),
        .rd_data(data_a), .pix_out(pix_a), .hsync(hs_a), .vsync(vs_a), .blank_n(bl_a)
    );

    always @(posedge clk) if (en_a) data_a <= addr_a[11:0];

    // ---------------- instance B: mid-size frame, CLK_DIV=2 ----------------
    logic        rst_b = 1'b1, req_b = 1'b0;
    logic        ack_b, fs_b, ref_b, en_b, bank_b, hs_b, vs_b, bl_b;
    logic [18:0] addr_b;
    logic [11:0] data_b = '0, pix_b;

    vga_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(2)
    ) dut_b (
        .clk(clk), .rst(rst_b), .swap_req(req_b), .swap_ack(ack_b), .front_sel(fs_b),
        .refresh(ref_b), .rd_en(en_b), .rd_bank(bank_b), .rd_addr(addr_b),
        .rd_data(data_b), .pix_out(pix_b), .hsync(hs_b), .vsync(vs_b), .blank_n(bl_b)
    );

    always @(posedge clk) if (en_b) data_b <= {bank_b, addr_b[10:0]};

    // ---------------- instance C: tiny frame, CLK_DIV=1 ----------------
    logic        rst_c = 1'b1, req_c = 1'b0;
    logic        ack_c, fs_c, ref_c, en_c, bank_c, hs_c, vs_c, bl_c;
    logic [18:0] addr_c;
    logic [11:0] data_c = '0, pix_c;

    vga_scanout #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(1)
    ) dut_c (
        .clk(clk), .rst(rst_c), .swap_req(req_c), .swap_ack(ack_c), .front_sel(fs_c),
        .refresh(ref_c), .rd_en(en_c), .rd_bank(bank_c), .rd_addr(addr_c),
        .rd_data(data_c), .pix_out(pix_c), .hsync(hs_c), .vsync(vs_c), .blank_n(bl_c)
    );

    always @(posedge clk) if (en_c) data_c <= {bank_c, addr_c[10:0]};

    // ---------------- A: table of expected values by clk after reset release ----------------
    typedef struct {
        int cyc;
        int en;
        int addr;
        int hs;
        int bl;
        int pix;
    } vec_t;

    localparam int NT = 17;
    vec_t tab[NT];

    task automatic run_a();
        int ti = 0;
        int hs_fall = -1, hs_prev_fall = -1, bl_rise = -1;
        logic phs = 1'b1, pbl = 1'b0;
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        for (int c = 0; c <= 3300; c++) begin
            if (c > 0) step();
            if (ti < NT && tab[ti].cyc == c) begin
                chk($sformatf("a_en@%0d", c),   int'(en_a),   tab[ti].en);
                chk($sformatf("a_addr@%0d", c), int'(addr_a), tab[ti].addr);
                chk($sformatf("a_hs@%0d", c),   int'(hs_a),   tab[ti].hs);
                chk($sformatf("a_bl@%0d", c),   int'(bl_a),   tab[ti].bl);
                chk($sformatf("a_pix@%0d", c),  int'(pix_a),  tab[ti].pix);
                chk($sformatf("a_vs@%0d", c),   int'(vs_a),   1);
                chk($sformatf("a_bank@%0d", c), int'(bank_a), 0);
                ti++;
            end
            if (!bl_a) chk("a_pix_blanked", int'(pix_a), 0);
            if (phs && !hs_a) begin
                if (hs_fall >= 0) chk("a_hsync_period", c - hs_fall, 1600);
                hs_prev_fall = hs_fall;
                hs_fall = c;
            end
            if (!phs && hs_a && hs_fall >= 0) chk("a_hsync_width", c - hs_fall, 192);
            if (!pbl && bl_a) bl_rise = c;
            if (pbl && !bl_a && bl_rise >= 0) chk("a_blank_width", c - bl_rise, 1280);
            phs = hs_a;
            pbl = bl_a;
        end
        chk("a_table_reached", ti, NT);
        chk("a_hsync_seen", int'(hs_prev_fall >= 0), 1);
    endtask

    // ---------------- B: swap sequences ----------------
    task automatic run_b();
        int tog = 0, acks = 0, refs = 0;
        logic pfs = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        for (int c = 0; c <= 1200; c++) begin
            if (c > 0) step();
            if (c == 105) begin
                chk("b_last_read_en", int'(en_b), 1);
                chk("b_last_read_addr", int'(addr_b), 31);
            end
            if (c == 119) begin
                chk("b_front_before_boundary", int'(fs_b), 0);
                chk("b_refresh_before_boundary", int'(ref_b), 0);
            end
            if (c == 120) begin
                chk("b_refresh_boundary", int'(ref_b), 1);
                chk("b_ack_boundary", int'(ack_b), 1);
                chk("b_front_after_swap", int'(fs_b), 1);
            end
            if (c == 121) begin
                chk("b_refresh_one_clk", int'(ref_b), 0);
                chk("b_ack_one_clk", int'(ack_b), 0);
            end
            if (c == 241) begin
                chk("b_newframe_en", int'(en_b), 1);
                chk("b_newframe_bank", int'(bank_b), 1);
                chk("b_newframe_addr", int'(addr_b), 0);
            end
            if (c == 360) begin
                chk("b_noreq_refresh", int'(ref_b), 1);
                chk("b_noreq_ack", int'(ack_b), 0);
                chk("b_noreq_front", int'(fs_b), 1);
            end
            if (fs_b != pfs) begin
                chk("b_swap_only_at_vblank", c % 240, 120);
                if (c >= 361) tog++;
            end
            if (ack_b && c >= 361) acks++;
            if (ref_b) refs++;
            pfs = fs_b;
            req_b = ((c >= 40 && c < 121) || (c >= 361 && c < 1081));
        end
        chk("b_held_toggles", tog, 3);
        chk("b_held_acks", acks, 3);
        chk("b_refresh_count", refs, 5);
        chk("b_front_final", int'(fs_b), 0);
    endtask

    // ---------------- C: arithmetic reference on the 7x5 frame ----------------
    function automatic int c_addr(input int p);
        int h = p % 7;
        int v = p / 7;
        if (v < 2) return v * 4 + ((h < 4) ? h : 4);
        return 8;
    endfunction

    function automatic int c_act(input int p);
        return int'(((p % 7) < 4) && ((p / 7) < 2));
    endfunction

    task automatic run_c();
        localparam int N = 700;
        bit req[N];
        bit fsm[N];
        int q_addr[$];
        int last_ref = -1;
        @(negedge clk);
        rst_c = 1'b0;
        #1;
        for (int c = 0; c < N; c++) begin
            int p, j, pj, ref_e, ack_e, bl_e, hs_e, vs_e, pix_e;
            if (c > 0) step();
            p     = c % 35;
            ref_e = int'(c >= 1 && ((c - 1) % 35) == 13);
            ack_e = (ref_e != 0 && req[c-1]) ? 1 : 0;
            fsm[c] = (c == 0) ? 1'b0 : (fsm[c-1] ^ (ack_e != 0));
            chk("c_rd_en", int'(en_c), c_act(p));
            chk("c_rd_addr", int'(addr_c), c_addr(p));
            chk("c_rd_bank", int'(bank_c), int'(fsm[c]));
            chk("c_front_sel", int'(fs_c), int'(fsm[c]));
            chk("c_refresh", int'(ref_c), ref_e);
            chk("c_swap_ack", int'(ack_c), ack_e);
            if (c >= 2) begin
                j     = c - 2;
                pj    = j % 35;
                bl_e  = c_act(pj);
                hs_e  = int'((pj % 7) != 5);
                vs_e  = int'((pj / 7) != 3);
                pix_e = bl_e != 0 ? ((int'(fsm[j]) << 11) | (c_addr(pj) & 'h7FF)) : 0;
            end else begin
                bl_e = 0; hs_e = 1; vs_e = 1; pix_e = 0;
            end
            chk("c_blank_n", int'(bl_c), bl_e);
            chk("c_hsync", int'(hs_c), hs_e);
            chk("c_vsync", int'(vs_c), vs_e);
            chk("c_pix_out", int'(pix_c), pix_e);
            if (en_c && q_addr.size() < 16) q_addr.push_back(int'(addr_c));
            if (ref_c) begin
                if (last_ref >= 0) chk("c_refresh_period", c - last_ref, 35);
                last_ref = c;
            end
            req[c] = 1'($urandom_range(0, 1));
            req_c  = req[c];
        end
        chk("c_addr_seq_len", q_addr.size(), 16);
        foreach (q_addr[i]) chk($sformatf("c_addr_seq[%0d]", i), q_addr[i], i % 8);
    endtask

    initial begin
        tab[0]  = '{cyc: 0,    en: 0, addr: 0,    hs: 1, bl: 0, pix: 0};
        tab[1]  = '{cyc: 1,    en: 1, addr: 0,    hs: 1, bl: 0, pix: 0};
        tab[2]  = '{cyc: 2,    en: 0, addr: 1,    hs: 1, bl: 0, pix: 0};
        tab[3]  = '{cyc: 3,    en: 1, addr: 1,    hs: 1, bl: 1, pix: 0};
        tab[4]  = '{cyc: 5,    en: 1, addr: 2,    hs: 1, bl: 1, pix: 1};
        tab[5]  = '{cyc: 1279, en: 1, addr: 639,  hs: 1, bl: 1, pix: 'h27E};
        tab[6]  = '{cyc: 1281, en: 0, addr: 640,  hs: 1, bl: 1, pix: 'h27F};
        tab[7]  = '{cyc: 1282, en: 0, addr: 640,  hs: 1, bl: 1, pix: 'h27F};
        tab[8]  = '{cyc: 1283, en: 0, addr: 640,  hs: 1, bl: 0, pix: 0};
        tab[9]  = '{cyc: 1314, en: 0, addr: 640,  hs: 1, bl: 0, pix: 0};
        tab[10] = '{cyc: 1315, en: 0, addr: 640,  hs: 0, bl: 0, pix: 0};
        tab[11] = '{cyc: 1506, en: 0, addr: 640,  hs: 0, bl: 0, pix: 0};
        tab[12] = '{cyc: 1507, en: 0, addr: 640,  hs: 1, bl: 0, pix: 0};
        tab[13] = '{cyc: 1601, en: 1, addr: 640,  hs: 1, bl: 0, pix: 0};
        tab[14] = '{cyc: 1603, en: 1, addr: 641,  hs: 1, bl: 1, pix: 'h280};
        tab[15] = '{cyc: 2914, en: 0, addr: 1280, hs: 1, bl: 0, pix: 0};
        tab[16] = '{cyc: 2915, en: 0, addr: 1280, hs: 0, bl: 0, pix: 0};

        repeat (3) @(negedge clk);
        run_a();

        // Mid-line reset while reads are active: values must drop without a clock edge
        #3;
        rst_a = 1'b1;
        #1;
        chk("rst_hsync", int'(hs_a), 1);
        chk("rst_vsync", int'(vs_a), 1);
        chk("rst_blank_n", int'(bl_a), 0);
        chk("rst_pix_out", int'(pix_a), 0);
        chk("rst_rd_en", int'(en_a), 0);
        chk("rst_rd_addr", int'(addr_a), 0);
        chk("rst_refresh", int'(ref_a), 0);
        chk("rst_swap_ack", int'(ack_a), 0);
        chk("rst_front_sel", int'(fs_a), 0);
        repeat (2) @(negedge clk);
        run_a();

        run_b();
        run_c();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Read-side partner of the graphics frame writer: scans the front frame buffer out to the VGA pins.
- Generates 640x480@60 timing from `clk` via a pixel-tick divider and issues linear read addresses to the front bank.
- Registers returned pixel data aligned with sync and blank.
- Pulses `refresh` at vblank start and performs double-buffer swaps on request, only at that vblank boundary.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, hsync pulse width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel tick (>=1)
- ADDR_W, 19, read address width (must hold H_ACTIVE*V_ACTIVE-1)
- PIX_W, 12, pixel width (4:4:4 RGB)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- swap_req  in  1  level: back buffer complete, swap wanted
- swap_ack  out  1  one-clk pulse: swap performed
- front_sel  out  1  bank being scanned; writer uses the other bank
- refresh  out  1  one-clk pulse at vblank start
- rd_en  out  1  frame-buffer read strobe
- rd_bank  out  1  bank for this read (= front_sel)
- rd_addr  out  ADDR_W  linear pixel address within the bank
- rd_data  in  PIX_W  pixel data, valid exactly 1 clk after rd_en
- pix_out  out  PIX_W  pixel to DAC; 0 when blanked
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- blank_n  out  1  high during the visible region

Behaviour:
- Reset (async, immediate) values:
  - all counters 0, front_sel 0
  - hsync 1, vsync 1, blank_n 0, pix_out 0
  - rd_en 0, rd_addr 0, refresh 0, swap_ack 0
- A reset mid-frame aborts the frame; scan restarts at h=0, v=0.
- Divider `div` counts 0..CLK_DIV-1; `tick` = (div == CLK_DIV-1). With CLK_DIV=1, tick is every cycle.
- On tick: `h_cnt` increments and wraps at H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. On h wrap, `v_cnt` increments and wraps at V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Position `active` = h_cnt < H_ACTIVE and v_cnt < V_ACTIVE, using the pre-update counter values at the tick.
- Read issue:
  - rd_en = tick and active (combinational on registered state); rd_addr = address counter; rd_bank = front_sel.
  - The address counter increments after each issued read and clears to 0 when h and v both wrap to 0.
  - Last address of a frame = H_ACTIVE*V_ACTIVE-1 (307199 at defaults).
- Output stage: one clk after each tick, the registered outputs update from that tick's position:
  - blank_n = active
  - pix_out = active ? rd_data : 0
  - hsync = 0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vsync = 0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC
- Outputs hold between ticks. Total latency from tick to pins is 1 clk, identical for pixel and sync.
- Vblank boundary = the tick where h wraps to 0 and v goes from V_ACTIVE-1 to V_ACTIVE.
  - refresh pulses for exactly one clk in the cycle after that tick.
  - If swap_req = 1 on that boundary tick: front_sel toggles and swap_ack pulses in the same clk as refresh.
  - If swap_req = 0: no toggle, no ack.
- swap_req has no effect at any other time; holding it high across several frames swaps once per frame.
- front_sel never changes while v_cnt < V_ACTIVE, so no tearing.

Test Plan:
- Reset:
  - Stimulus: assert rst mid-line with outputs active.
  - Response: outputs immediately take reset values. After release, first rd_en comes CLK_DIV clks later with rd_addr=0, rd_bank=0.
- Line/frame timing (defaults, CLK_DIV=2):
  - hsync low for 192 clks, period 1600 clks.
  - vsync low for 2 lines = 3200 clks, frame period 840000 clks.
  - blank_n high for 1280 clks per line.
- Address/data path:
  - Stimulus: memory model returns rd_data = rd_addr[11:0] one clk after rd_en.
  - Response: first visible pix_out=0x000. Last pixel of line 0 = 0x27F. Last read of frame has rd_addr=307199. pix_out=0 whenever blank_n=0.
- Swap granted:
  - Stimulus: swap_req=1 during line 100.
  - Response: no change until the line-480 boundary. Then front_sel 0->1, swap_ack and refresh coincident 1-clk pulses. Next frame reads use rd_bank=1.
- Swap not requested:
  - Stimulus: swap_req=0 across a boundary.
  - Response: refresh pulses, swap_ack stays 0, front_sel unchanged.
  - Stimulus: swap_req=1 held for 3 frames.
  - Response: exactly 3 toggles.
- Reduced parameters (H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1, V_ACTIVE=2, V_FP/V_SYNC/V_BP=1, CLK_DIV=1):
  - Response: rd_addr sequence 0..7 then wraps to 0. refresh every 35 clks.
